// File: rtl/agen_sched.sv
// AGEN unit sequencer: converts one-hot issue vectors to qids, runs each unit through a fixed
// latency with an optional TLB-miss wait, and returns done qids. AGEN_PERF_CNT_EN adds perf counters.
module agen_sched #(
  parameter int IQ_ENTRIES = 8,
  parameter int QIDW       = 3,
  parameter int AGEN_LAT   = 2,
  parameter int NUM_AGEN   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [IQ_ENTRIES-1:0] issue0,
  input  logic [IQ_ENTRIES-1:0] issue1,
  input  logic                  flush,
  input  logic [NUM_AGEN-1:0]   tlb_miss,
  input  logic                  tlb_ready,
  output logic                  agen0_idle,
  output logic                  agen1_idle,
  output logic [NUM_AGEN-1:0]   done_v,
  output logic [QIDW-1:0]       done_qid0,
  output logic [QIDW-1:0]       done_qid1,
  output logic                  issue_err
`ifdef AGEN_PERF_CNT_EN
  ,
  output logic [31:0]           busy_cyc0,
  output logic [31:0]           busy_cyc1,
  output logic [31:0]           tlbw_cyc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_TLBW} state_t;

  localparam logic [3:0] CNT_INIT = 4'(AGEN_LAT - 1);
  localparam logic [1:0] UNIT_EN  = (NUM_AGEN > 1) ? 2'b11 : 2'b01;

  state_t                r_state [2];
  state_t                w_state_nx [2];
  logic [3:0]            r_cnt [2];
  logic [3:0]            w_cnt_nx [2];
  logic [QIDW-1:0]       r_qid [2];
  logic [QIDW-1:0]       w_qid_nx [2];
  logic [QIDW-1:0]       r_dqid [2];
  logic                  r_rel [2];
  logic                  w_rel_nx [2];
  logic [IQ_ENTRIES-1:0] w_issue [2];
  logic [QIDW-1:0]       w_low [2];
  logic [1:0]            w_done;
  logic [1:0]            w_idle;
  logic [1:0]            w_busy_iss;
  logic [1:0]            w_miss;
  logic                  r_err;

  assign w_issue[0] = issue0;
  assign w_issue[1] = UNIT_EN[1] ? issue1 : '0;
  assign w_miss     = 2'(tlb_miss);

  always_comb begin
    for (int unsigned u = 0; u < 2; u++) begin
      w_low[u] = '0;
      for (int unsigned i = IQ_ENTRIES; i > 0; i--) begin
        if (w_issue[u][i-1]) w_low[u] = QIDW'(i - 1);
      end
    end
  end

  // Idle is derived from the next state before accept, so a unit finishing this cycle
  // can take a new issue on the same edge.
  always_comb begin
    for (int unsigned u = 0; u < 2; u++) begin
      w_state_nx[u] = r_state[u];
      w_cnt_nx[u]   = r_cnt[u];
      w_qid_nx[u]   = r_qid[u];
      w_rel_nx[u]   = r_rel[u];
      w_done[u]     = 1'b0;
      w_busy_iss[u] = 1'b0;
      case (r_state[u])
        S_BUSY: begin
          if (r_cnt[u] == '0) begin
            if (w_miss[u]) begin
              w_state_nx[u] = S_TLBW;
            end else begin
              w_done[u]     = 1'b1;
              w_state_nx[u] = S_IDLE;
            end
          end else begin
            w_cnt_nx[u] = r_cnt[u] - 4'd1;
          end
        end
        S_TLBW: begin
          if (r_rel[u]) begin
            w_done[u]     = 1'b1;
            w_state_nx[u] = S_IDLE;
            w_rel_nx[u]   = 1'b0;
          end else if (tlb_ready) begin
            w_rel_nx[u] = 1'b1;
          end
        end
        default: ;
      endcase
      if (flush) begin
        w_state_nx[u] = S_IDLE;
        w_rel_nx[u]   = 1'b0;
        w_done[u]     = 1'b0;
      end
      w_idle[u] = UNIT_EN[u] && (w_state_nx[u] == S_IDLE);
      if (w_issue[u] != '0) begin
        if (!w_idle[u]) begin
          w_busy_iss[u] = 1'b1;
        end else if (!flush) begin
          w_state_nx[u] = S_BUSY;
          w_cnt_nx[u]   = CNT_INIT;
          w_qid_nx[u]   = w_low[u];
          w_rel_nx[u]   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned u = 0; u < 2; u++) begin
        r_state[u] <= S_IDLE;
        r_cnt[u]   <= '0;
        r_qid[u]   <= '0;
        r_dqid[u]  <= '0;
        r_rel[u]   <= 1'b0;
      end
      r_err <= 1'b0;
    end else if (ce) begin
      for (int unsigned u = 0; u < 2; u++) begin
        r_state[u] <= w_state_nx[u];
        r_cnt[u]   <= w_cnt_nx[u];
        r_qid[u]   <= w_qid_nx[u];
        r_rel[u]   <= w_rel_nx[u];
        if (w_done[u]) r_dqid[u] <= r_qid[u];
      end
      r_err <= r_err | (|w_busy_iss);
    end
  end

  assign agen0_idle = w_idle[0];
  assign agen1_idle = w_idle[1];
  assign done_v     = w_done[NUM_AGEN-1:0];
  assign done_qid0  = w_done[0] ? r_qid[0] : r_dqid[0];
  assign done_qid1  = w_done[1] ? r_qid[1] : r_dqid[1];
  assign issue_err  = r_err;

`ifdef AGEN_PERF_CNT_EN
  logic [31:0] r_busy_cyc [2];
  logic [31:0] r_tlbw_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cyc[0] <= '0;
      r_busy_cyc[1] <= '0;
      r_tlbw_cyc    <= '0;
    end else if (ce) begin
      for (int unsigned u = 0; u < 2; u++) begin
        if (r_state[u] != S_IDLE) r_busy_cyc[u] <= r_busy_cyc[u] + 32'd1;
      end
      if (r_state[0] == S_TLBW || r_state[1] == S_TLBW) r_tlbw_cyc <= r_tlbw_cyc + 32'd1;
    end
  end

  assign busy_cyc0 = r_busy_cyc[0];
  assign busy_cyc1 = r_busy_cyc[1];
  assign tlbw_cyc  = r_tlbw_cyc;
`endif

endmodule

// File: tb/tb_agen_sched.sv
// Bench for agen_sched: directed plan steps then random traffic, checked every cycle against a
// timestamp-based model (job due time, TLB wait, release) rather than a countdown FSM.
module tb_agen_sched;

  localparam int LAT = 2;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [7:0] issue0;
  logic [7:0] issue1;
  logic       flush;
  logic [1:0] tlb_miss;
  logic       tlb_ready;
  logic       agen0_idle;
  logic       agen1_idle;
  logic [1:0] done_v;
  logic [2:0] done_qid0;
  logic [2:0] done_qid1;
  logic       issue_err;

  agen_sched #(
    .IQ_ENTRIES(8),
    .QIDW      (3),
    .AGEN_LAT  (LAT),
    .NUM_AGEN  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .issue0    (issue0),
    .issue1    (issue1),
    .flush     (flush),
    .tlb_miss  (tlb_miss),
    .tlb_ready (tlb_ready),
    .agen0_idle(agen0_idle),
    .agen1_idle(agen1_idle),
    .done_v    (done_v),
    .done_qid0 (done_qid0),
    .done_qid1 (done_qid1),
    .issue_err (issue_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int n_cyc  = 0;

  // Reference model: t counts ce-enabled edges; a job completes in the cycle where t == due.
  int         t;
  bit         m_busy [2];
  bit         m_wait [2];
  bit         m_rel  [2];
  int         m_due  [2];
  logic [2:0] m_qid  [2];
  logic [2:0] m_last [2];
  bit         m_err;
  bit         e_raw  [2];
  bit         e_done [2];
  bit         e_idle [2];

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [7:0] iso;
    iso = v & (~v + 8'd1);
    return 3'($clog2(iso));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, n_cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_err = 0;
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 0; m_wait[u] = 0; m_rel[u] = 0; m_due[u] = 0;
      m_qid[u] = '0; m_last[u] = '0;
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic fl,
                       input logic [1:0] ms, input logic rd, input logic c);
    logic [7:0] iss [2];
    issue0 = a; issue1 = b; flush = fl; tlb_miss = ms; tlb_ready = rd; ce = c;
    #2;
    iss[0] = a; iss[1] = b;
    for (int u = 0; u < 2; u++) begin
      e_raw[u]  = (m_busy[u] && !m_wait[u] && t == m_due[u] && !ms[u]) || (m_wait[u] && m_rel[u]);
      e_done[u] = e_raw[u] && !fl;
      e_idle[u] = fl || !m_busy[u] || e_raw[u];
    end
    check("done_v", 32'(done_v), {30'd0, e_done[1], e_done[0]});
    check("idle0", 32'(agen0_idle), 32'(e_idle[0]));
    check("idle1", 32'(agen1_idle), 32'(e_idle[1]));
    check("qid0", 32'(done_qid0), 32'(e_done[0] ? m_qid[0] : m_last[0]));
    check("qid1", 32'(done_qid1), 32'(e_done[1] ? m_qid[1] : m_last[1]));
    check("issue_err", 32'(issue_err), 32'(m_err));
  endtask

  task automatic tick();
    logic [7:0] iss [2];
    int tn;
    iss[0] = issue0; iss[1] = issue1;
    if (rst) begin
      model_reset();
    end else if (ce) begin
      tn = t + 1;
      for (int u = 0; u < 2; u++) begin
        if (flush) begin
          m_busy[u] = 0; m_wait[u] = 0; m_rel[u] = 0;
        end else begin
          if (e_done[u]) begin
            m_busy[u] = 0; m_wait[u] = 0; m_rel[u] = 0;
            m_last[u] = m_qid[u];
          end else if (m_busy[u] && !m_wait[u] && t == m_due[u] && tlb_miss[u]) begin
            m_wait[u] = 1;
          end else if (m_wait[u] && !m_rel[u] && tlb_ready) begin
            m_rel[u] = 1;
          end
          if (iss[u] != 8'd0 && e_idle[u]) begin
            m_busy[u] = 1; m_wait[u] = 0; m_rel[u] = 0;
            m_qid[u] = lowest(iss[u]);
            m_due[u] = tn + LAT - 1;
          end
        end
        if (iss[u] != 8'd0 && !e_idle[u]) m_err = 1;
      end
      t = tn;
    end
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic drv0();
    drive(8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] r [2];
    rst = 1'b1; ce = 1'b1; issue0 = '0; issue1 = '0; flush = 1'b0; tlb_miss = '0; tlb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // reset state
    drv0();
    check("rst_idle0", 32'(agen0_idle), 32'd1);
    check("rst_idle1", 32'(agen1_idle), 32'd1);
    check("rst_done", 32'(done_v), 32'd0);
    check("rst_err", 32'(issue_err), 32'd0);
    check("rst_qid0", 32'(done_qid0), 32'd0);
    tick();

    // basic latency
    drive(8'h10, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); tick();
    drv0(); check("lat_idle_low", 32'(agen0_idle), 32'd0); tick();
    drv0();
    check("lat_done", 32'(done_v), 32'h1);
    check("lat_qid", 32'(done_qid0), 32'd4);
    check("lat_idle_high", 32'(agen0_idle), 32'd1);
    tick();

    // streaming, back-to-back on the done cycle
    drive(8'h01, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); tick();
    drv0(); tick();
    drive(8'h02, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    check("str_q0", 32'(done_qid0), 32'd0); check("str_d0", 32'(done_v), 32'h1); tick();
    drv0(); tick();
    drive(8'h04, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    check("str_q1", 32'(done_qid0), 32'd1); check("str_d1", 32'(done_v), 32'h1); tick();
    drv0(); tick();
    drv0();
    check("str_q2", 32'(done_qid0), 32'd2); check("str_d2", 32'(done_v), 32'h1);
    check("str_err", 32'(issue_err), 32'd0);
    tick();

    // TLB miss on unit 1
    drive(8'h00, 8'h80, 1'b0, 2'b00, 1'b0, 1'b1); tick();
    drv0(); tick();
    drive(8'h00, 8'h00, 1'b0, 2'b10, 1'b0, 1'b1); check("tlb_nodone", 32'(done_v), 32'd0); tick();
    for (int k = 0; k < 4; k++) begin
      drv0(); check("tlb_wait", 32'(done_v), 32'd0); check("tlb_busy", 32'(agen1_idle), 32'd0); tick();
    end
    drive(8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1); check("tlb_rdy_nodone", 32'(done_v), 32'd0); tick();
    drv0();
    check("tlb_done", 32'(done_v), 32'h2);
    check("tlb_qid", 32'(done_qid1), 32'd7);
    tick();

    // issue to a busy unit
    drive(8'h20, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); tick();
    drive(8'h02, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); check("bsy_idle", 32'(agen0_idle), 32'd0); tick();
    drv0();
    check("bsy_done", 32'(done_v), 32'h1);
    check("bsy_qid", 32'(done_qid0), 32'd5);
    check("bsy_err", 32'(issue_err), 32'd1);
    tick();
    drv0(); check("bsy_err_sticky", 32'(issue_err), 32'd1); tick();

    // flush with an issue present
    drive(8'h01, 8'h02, 1'b0, 2'b00, 1'b0, 1'b1); tick();
    drive(8'h08, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1); check("fl_nodone", 32'(done_v), 32'd0); tick();
    drv0();
    check("fl_idle0", 32'(agen0_idle), 32'd1);
    check("fl_idle1", 32'(agen1_idle), 32'd1);
    check("fl_done", 32'(done_v), 32'd0);
    tick();
    drv0(); check("fl_dropped", 32'(done_v), 32'd0); tick();

    // multi-hot issue and ce hold
    drive(8'h0C, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1); tick();
    for (int k = 0; k < 3; k++) begin
      drive(8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0); check("ce_hold", 32'(done_v), 32'd0); tick();
    end
    drv0(); check("ce_notyet", 32'(done_v), 32'd0); tick();
    drv0();
    check("ce_done", 32'(done_v), 32'h1);
    check("ce_qid", 32'(done_qid0), 32'd2);
    tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int u = 0; u < 2; u++) begin
        if ($urandom_range(1, 0) == 0) r[u] = 8'h00;
        else if ($urandom_range(9, 0) < 7) r[u] = 8'h01 << $urandom_range(7, 0);
        else r[u] = 8'($urandom_range(255, 1));
      end
      rst = ($urandom_range(149, 0) == 0);
      drive(r[0], r[1], $urandom_range(24, 0) == 0,
            {$urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0},
            $urandom_range(3, 0) == 0, $urandom_range(7, 0) != 0);
      tick();
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
